crc_err_inject_ctrl: RTL



---
 rtl/crc_pkg.sv | 30 +++
 rtl/crc_err_lfsr.sv | 25 ++
 rtl/crc_err_inject_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared constants for the CRC error-injection controller: default widths,
// mode and FSM encodings, and the LFSR polynomial.
package crc_pkg;

  localparam int N_DEF  = 11;
  localparam int M_DEF  = 5;
  localparam int CW_DEF = N_DEF + M_DEF - 1;

  // Injection modes as presented on cfg_mode
  localparam logic [1:0] MODE_OFF      = 2'd0;
  localparam logic [1:0] MODE_SHOT     = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;
  localparam logic [1:0] MODE_RANDOM   = 2'd3;

  // Controller FSM states
  localparam logic [1:0] ST_OFF       = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_SHOT_WAIT = 2'd2;
  localparam logic [1:0] ST_SHOT_DONE = 2'd3;

  // x^8+x^6+x^5+x^4+1, Fibonacci form: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEF = 8'h01;

  // Feedback bit shifted into bit 0 on each advance
  function automatic logic lfsr_fb(input logic [7:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/crc_err_lfsr.sv
// 8-bit left-shifting Fibonacci LFSR that supplies random flip positions.
// A zero seed would lock the register, so it is replaced by the default.
module crc_err_lfsr
  import crc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] state
);

  // Seed on load, otherwise step once per advance pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_SEED_DEF;
    end else if (load) begin
      state <= (seed == 8'h00) ? LFSR_SEED_DEF : seed;
    end else if (advance) begin
      state <= {state[6:0], lfsr_fb(state)};
    end
  end

endmodule

// File: rtl/crc_err_inject_ctrl.sv
// CRC error-injection controller: passes codewords through a one-deep
// output register and, depending on the configured mode, inverts exactly
// one bit of selected codewords while counting the injected errors.
module crc_err_inject_ctrl
  import crc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  cfg_mode,
  input  logic [CNT_W-1:0]            cfg_period,
  input  logic [$clog2(N+M-1)-1:0]    cfg_pos,
  input  logic [7:0]                  cfg_seed,
  input  logic                        cfg_load,
  input  logic                        arm,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N+M-2:0]              in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N+M-2:0]              out_data,
  output logic                        out_err,
  output logic [$clog2(N+M-1)-1:0]    out_err_pos,
  output logic [CNT_W-1:0]            err_count
);

  localparam int CW    = N + M - 1;
  localparam int POS_W = $clog2(CW);

  logic [1:0]       state;
  logic [CNT_W-1:0] period_cfg;   // never zero once loaded
  logic [POS_W-1:0] pos_cfg;      // already clamped to CW-1
  logic             random_mode;
  logic [CNT_W-1:0] period_cnt;
  logic [7:0]       lfsr_state;

  logic             accept;
  logic             period_hit;
  logic             corrupt;
  logic [POS_W-1:0] flip_pos;
  logic [POS_W-1:0] lfsr_low;
  logic [POS_W-1:0] rand_pos;
  logic [POS_W-1:0] pos_clamped;
  logic [CW-1:0]    flip_mask;

  assign in_ready = (!out_valid || out_ready) && !cfg_load;
  assign accept   = in_valid && in_ready;

  assign period_hit  = (period_cnt == (period_cfg - CNT_W'(1)));
  assign lfsr_low    = lfsr_state[POS_W-1:0];
  assign rand_pos    = (int'(lfsr_low) >= CW) ? POS_W'(int'(lfsr_low) - CW) : lfsr_low;
  assign pos_clamped = (int'(cfg_pos) >= CW) ? POS_W'(CW - 1) : cfg_pos;
  assign flip_mask   = CW'(1) << flip_pos;

  // Decide whether the codeword presented now is corrupted, and where
  always_comb begin
    corrupt  = 1'b0;
    flip_pos = '0;
    case (state)
      ST_SHOT_WAIT: begin
        corrupt  = 1'b1;
        flip_pos = pos_cfg;
      end
      ST_RUN: begin
        corrupt  = period_hit;
        flip_pos = random_mode ? rand_pos : pos_cfg;
      end
      default: begin
        corrupt  = 1'b0;
        flip_pos = '0;
      end
    endcase
  end

  // Configuration latch, FSM, period counter and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      period_cfg  <= CNT_W'(1);
      pos_cfg     <= '0;
      random_mode <= 1'b0;
      period_cnt  <= '0;
      err_count   <= '0;
    end else if (cfg_load) begin
      // cfg_load overrides arm; no codeword is accepted in this cycle
      period_cfg  <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
      pos_cfg     <= pos_clamped;
      random_mode <= (cfg_mode == MODE_RANDOM);
      period_cnt  <= '0;
      err_count   <= '0;
      case (cfg_mode)
        MODE_OFF:  state <= ST_OFF;
        MODE_SHOT: state <= ST_SHOT_WAIT;
        default:   state <= ST_RUN;
      endcase
    end else begin
      if (accept && state == ST_RUN) begin
        period_cnt <= period_hit ? '0 : period_cnt + CNT_W'(1);
      end
      if (accept && state == ST_SHOT_WAIT) begin
        state <= ST_SHOT_DONE;
      end else if (arm && state == ST_SHOT_DONE) begin
        state <= ST_SHOT_WAIT;
      end
      if (accept && corrupt && err_count != '1) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  // Output register: loads on accept, drains when downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err     <= 1'b0;
      out_err_pos <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= corrupt ? (in_data ^ flip_mask) : in_data;
      out_err     <= corrupt;
      out_err_pos <= corrupt ? flip_pos : '0;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  crc_err_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cfg_load),
    .seed    (cfg_seed),
    .advance (accept && state == ST_RUN),
    .state   (lfsr_state)
  );

endmodule
